// File: rtl/mips_pkg.sv
//============================================================================
// Module      : mips_pkg
// Description : Shared MIPS datapath constants and the register address type
//               used by decode, write-back and the register file.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package mips_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef logic [ADDR_W-1:0] reg_addr_t;

endpackage : mips_pkg

`default_nettype wire

// File: rtl/rf_scoreboard.sv
//============================================================================
// Module      : rf_scoreboard
// Description : Pending-write vector for in-flight destinations, with
//               registered RAW hazard lookups for both decode read ports.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module rf_scoreboard
    import mips_pkg::*;
#(
    parameter int ADDR_W = mips_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_in,
    input  logic              rf_we,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic              claim_en,
    input  logic [ADDR_W-1:0] claim_addr,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic              hazard_a,
    output logic              hazard_b
);

    localparam int c_DEPTH = 2 ** ADDR_W;

    logic [c_DEPTH-1:0] r_pending;
    logic [c_DEPTH-1:0] w_clr_mask;
    logic [c_DEPTH-1:0] w_set_mask;
    logic [c_DEPTH-1:0] w_after_clear;
    logic [c_DEPTH-1:0] w_pending_next;

    // Set is applied after clear so a newer claim outlives a same-cycle retire.
    always_comb begin
        w_clr_mask = '0;
        w_set_mask = '0;
        if (rf_we) begin
            w_clr_mask[write_addr] = 1'b1;
        end
        if (claim_en && !stall_in) begin
            w_set_mask[claim_addr] = 1'b1;
        end
        w_after_clear            = r_pending & ~w_clr_mask;
        w_pending_next           = w_after_clear | w_set_mask;
        w_pending_next[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
            hazard_a  <= 1'b0;
            hazard_b  <= 1'b0;
        end else begin
            r_pending <= w_pending_next;
            if (!stall_in) begin
                hazard_a <= w_after_clear[rd_addr_a];
                hazard_b <= w_after_clear[rd_addr_b];
            end
        end
    end

endmodule : rf_scoreboard

`default_nettype wire

// File: rtl/register_file.sv
//============================================================================
// Module      : register_file
// Description : 32 x 32 MIPS GPR file, two registered read ports and a
//               pending-write scoreboard. Define REGFILE_BYPASS_EN for
//               write-first forwarding on the read ports.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module register_file
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int ADDR_W = mips_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_in,
    input  logic              rf_we,
    input  logic [ADDR_W-1:0] write_addr_in,
    input  logic [DATA_W-1:0] write_data_in,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              claim_en,
    input  logic [ADDR_W-1:0] claim_addr,
    output logic              hazard_a,
    output logic              hazard_b
);

    localparam int c_DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [c_DEPTH];
    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;
    logic              w_wr_valid;

    assign w_wr_valid = rf_we && (write_addr_in != REG_ZERO);

    always_comb begin
        w_rd_a = r_mem[rd_addr_a];
        w_rd_b = r_mem[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
        if (w_wr_valid && (write_addr_in == rd_addr_a)) begin
            w_rd_a = write_data_in;
        end
        if (w_wr_valid && (write_addr_in == rd_addr_b)) begin
            w_rd_b = write_data_in;
        end
`endif
        if (rd_addr_a == REG_ZERO) begin
            w_rd_a = '0;
        end
        if (rd_addr_b == REG_ZERO) begin
            w_rd_b = '0;
        end
    end

    // Write-back has already committed, so the array update ignores stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            rd_data_a <= '0;
            rd_data_b <= '0;
        end else begin
            if (w_wr_valid) begin
                r_mem[write_addr_in] <= write_data_in;
            end
            if (!stall_in) begin
                rd_data_a <= w_rd_a;
                rd_data_b <= w_rd_b;
            end
        end
    end

    rf_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .stall_in   (stall_in),
        .rf_we      (rf_we),
        .write_addr (write_addr_in),
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .hazard_a   (hazard_a),
        .hazard_b   (hazard_b)
    );

endmodule : register_file

`default_nettype wire

// File: tb/tb_register_file.sv
//============================================================================
// Module      : tb_register_file
// Description : Self-checking bench for register_file against an array model.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_register_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_in;
    logic        rf_we;
    logic [4:0]  write_addr_in;
    logic [31:0] write_data_in;
    logic [4:0]  rd_addr_a;
    logic [4:0]  rd_addr_b;
    logic [31:0] rd_data_a;
    logic [31:0] rd_data_b;
    logic        claim_en;
    logic [4:0]  claim_addr;
    logic        hazard_a;
    logic        hazard_b;

    int total = 0;
    int bad   = 0;

    // Reference state
    logic [31:0] m_mem [32];
    bit          m_pend [32];
    logic [31:0] e_a, e_b;
    logic        e_ha, e_hb;

    always #5 clk = ~clk;

    register_file dut (
        .clk           (clk),
        .rst           (rst),
        .stall_in      (stall_in),
        .rf_we         (rf_we),
        .write_addr_in (write_addr_in),
        .write_data_in (write_data_in),
        .rd_addr_a     (rd_addr_a),
        .rd_addr_b     (rd_addr_b),
        .rd_data_a     (rd_data_a),
        .rd_data_b     (rd_data_b),
        .claim_en      (claim_en),
        .claim_addr    (claim_addr),
        .hazard_a      (hazard_a),
        .hazard_b      (hazard_b)
    );

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = 32'h0;
            m_pend[i] = 1'b0;
        end
        e_a = 32'h0; e_b = 32'h0; e_ha = 1'b0; e_hb = 1'b0;
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] ra, input logic we,
                                               input logic [4:0] wa, input logic [31:0] wd);
        if (ra == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (we && wa == ra) return wd;
`endif
        return m_mem[ra];
    endfunction

    // Drives one clock's inputs, predicts the outcome, samples 1 ns after the edge.
    task automatic cyc(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra, input logic [4:0] rb,
                       input logic ce, input logic [4:0] ca, input logic st);
        rf_we = we; write_addr_in = wa; write_data_in = wd;
        rd_addr_a = ra; rd_addr_b = rb;
        claim_en = ce; claim_addr = ca; stall_in = st;
        if (we) m_pend[wa] = 1'b0;
        if (!st) begin
            e_a  = model_read(ra, we, wa, wd);
            e_b  = model_read(rb, we, wa, wd);
            e_ha = m_pend[ra];
            e_hb = m_pend[rb];
        end
        if (we && wa != 5'd0) m_mem[wa] = wd;
        if (ce && !st && ca != 5'd0) m_pend[ca] = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        model_reset();
        total++; if (rd_data_a !== 32'h0) begin bad++; $display("FAIL reset_rd_a got=%h exp=0", rd_data_a); end
        total++; if (rd_data_b !== 32'h0) begin bad++; $display("FAIL reset_rd_b got=%h exp=0", rd_data_b); end
        total++; if ({hazard_a, hazard_b} !== 2'b00) begin bad++; $display("FAIL reset_haz got=%b exp=00", {hazard_a, hazard_b}); end
        @(negedge clk); rst = 1'b0;
        cyc(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 1'b1, 5'd6, 1'b0);
        cyc(1'b0, 5'd0, 32'h0, 5'd5, 5'd6, 1'b0, 5'd0, 1'b0);
        total++; if (rd_data_a !== 32'hDEADBEEF) begin bad++; $display("FAIL pre_reset_r5 got=%h exp=deadbeef", rd_data_a); end
        total++; if (hazard_b !== 1'b1) begin bad++; $display("FAIL pre_reset_haz6 got=%b exp=1", hazard_b); end
        // Mid-cycle asynchronous reset
        #2; rst = 1'b1; #1;
        model_reset();
        total++; if (rd_data_a !== 32'h0) begin bad++; $display("FAIL async_rst_rd_a got=%h exp=0", rd_data_a); end
        total++; if (hazard_b !== 1'b0) begin bad++; $display("FAIL async_rst_haz_b got=%b exp=0", hazard_b); end
        @(negedge clk); rst = 1'b0;
        cyc(1'b0, 5'd0, 32'h0, 5'd5, 5'd6, 1'b0, 5'd0, 1'b0);
        total++; if (rd_data_a !== 32'h0) begin bad++; $display("FAIL post_rst_r5 got=%h exp=0", rd_data_a); end
        total++; if (hazard_b !== 1'b0) begin bad++; $display("FAIL post_rst_haz6 got=%b exp=0", hazard_b); end
    endtask

    task automatic test_write_read();
        cyc(1'b1, 5'd3, 32'h12345678, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        cyc(1'b0, 5'd0, 32'h0, 5'd3, 5'd3, 1'b0, 5'd0, 1'b0);
        total++; if (rd_data_a !== 32'h12345678) begin bad++; $display("FAIL write_read_a got=%h exp=12345678", rd_data_a); end
        total++; if (rd_data_b !== 32'h12345678) begin bad++; $display("FAIL write_read_b got=%h exp=12345678", rd_data_b); end
    endtask

    task automatic test_zero_reg();
        cyc(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
        cyc(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        total++; if ({rd_data_a, rd_data_b} !== 64'h0) begin bad++; $display("FAIL zero_reg got=%h/%h exp=0/0", rd_data_a, rd_data_b); end
        total++; if ({hazard_a, hazard_b} !== 2'b00) begin bad++; $display("FAIL zero_haz got=%b exp=00", {hazard_a, hazard_b}); end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_b;
`ifdef REGFILE_BYPASS_EN
        exp_b = 32'hA5A5A5A5;
`else
        exp_b = 32'h11111111;
`endif
        cyc(1'b1, 5'd7, 32'h11111111, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        cyc(1'b1, 5'd7, 32'hA5A5A5A5, 5'd0, 5'd7, 1'b0, 5'd0, 1'b0);
        total++; if (rd_data_b !== exp_b) begin bad++; $display("FAIL bypass_b got=%h exp=%h", rd_data_b, exp_b); end
        cyc(1'b0, 5'd0, 32'h0, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0);
        total++; if (rd_data_a !== 32'hA5A5A5A5) begin bad++; $display("FAIL bypass_after got=%h exp=a5a5a5a5", rd_data_a); end
    endtask

    task automatic test_scoreboard();
        cyc(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd9, 1'b0);
        cyc(1'b0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0);
        total++; if (hazard_a !== 1'b1) begin bad++; $display("FAIL claim_haz got=%b exp=1", hazard_a); end
        cyc(1'b1, 5'd9, 32'h99, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0);
        total++; if (hazard_a !== 1'b0) begin bad++; $display("FAIL wb_clears_haz got=%b exp=0", hazard_a); end
        cyc(1'b1, 5'd9, 32'h98, 5'd9, 5'd0, 1'b1, 5'd9, 1'b0);
        total++; if (hazard_a !== 1'b0) begin bad++; $display("FAIL same_cycle_no_self_haz got=%b exp=0", hazard_a); end
        cyc(1'b0, 5'd0, 32'h0, 5'd9, 5'd9, 1'b0, 5'd0, 1'b0);
        total++; if ({hazard_a, hazard_b} !== 2'b11) begin bad++; $display("FAIL set_wins got=%b exp=11", {hazard_a, hazard_b}); end
        cyc(1'b1, 5'd9, 32'h97, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic test_stall();
        cyc(1'b1, 5'd1, 32'hCAFE0001, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        cyc(1'b0, 5'd0, 32'h0, 5'd1, 5'd3, 1'b0, 5'd0, 1'b0);
        cyc(1'b1, 5'd12, 32'h0BADF00D, 5'd2, 5'd12, 1'b1, 5'd4, 1'b1);
        total++; if (rd_data_a !== 32'hCAFE0001) begin bad++; $display("FAIL stall_hold_a got=%h exp=cafe0001", rd_data_a); end
        total++; if (rd_data_b !== 32'h12345678) begin bad++; $display("FAIL stall_hold_b got=%h exp=12345678", rd_data_b); end
        cyc(1'b0, 5'd0, 32'h0, 5'd4, 5'd12, 1'b0, 5'd0, 1'b0);
        total++; if (hazard_a !== 1'b0) begin bad++; $display("FAIL stall_claim_ignored got=%b exp=0", hazard_a); end
        total++; if (rd_data_b !== 32'h0BADF00D) begin bad++; $display("FAIL stall_write got=%h exp=0badf00d", rd_data_b); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            cyc(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                ($urandom_range(0, 3) == 0));
            total++; if (rd_data_a !== e_a) begin bad++; $display("FAIL rand_rd_a n=%0d got=%h exp=%h", n, rd_data_a, e_a); end
            total++; if (rd_data_b !== e_b) begin bad++; $display("FAIL rand_rd_b n=%0d got=%h exp=%h", n, rd_data_b, e_b); end
            total++; if (hazard_a !== e_ha) begin bad++; $display("FAIL rand_haz_a n=%0d got=%b exp=%b", n, hazard_a, e_ha); end
            total++; if (hazard_b !== e_hb) begin bad++; $display("FAIL rand_haz_b n=%0d got=%b exp=%b", n, hazard_b, e_hb); end
        end
    endtask

    initial begin
        rst = 1'b1; stall_in = 1'b0; rf_we = 1'b0; write_addr_in = '0; write_data_in = '0;
        rd_addr_a = '0; rd_addr_b = '0; claim_en = 1'b0; claim_addr = '0;
        model_reset();
        test_reset();
        test_write_read();
        test_zero_reg();
        test_bypass();
        test_scoreboard();
        test_stall();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_register_file

`default_nettype wire

// File: doc/register_file.md
Name: register_file

Overview:
- 32-entry x 32-bit MIPS general-purpose register file: the receiving end of the write-back port.
- Accepts rf_we / write_addr / write_data from the write-back stage.
- Serves two registered read ports to decode.
- Keeps a pending-write scoreboard so decode can detect RAW hazards on registers that are still in flight.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; depth = 2**ADDR_W

Ports:
clk  input  1  CPU clock, rising edge
rst  input  1  asynchronous active-high reset
stall_in  input  1  pipeline stall; holds read outputs and scoreboard claims
rf_we  input  1  write enable from write-back
write_addr_in  input  ADDR_W  destination register from write-back
write_data_in  input  DATA_W  value to write
rd_addr_a  input  ADDR_W  read port A address (rs)
rd_addr_b  input  ADDR_W  read port B address (rt)
rd_data_a  output  DATA_W  registered read data A
rd_data_b  output  DATA_W  registered read data B
claim_en  input  1  decode issues an instruction that will write claim_addr
claim_addr  input  ADDR_W  destination being claimed
hazard_a  output  1  registered: rd_addr_a is pending in scoreboard
hazard_b  output  1  registered: rd_addr_b is pending in scoreboard

Behaviour:
- Reset (async, rst=1):
  - all 32 registers clear to 0; rd_data_a/b = 0; hazard_a/b = 0.
  - scoreboard (32-bit pending vector) cleared.
  - Reset asserted mid-operation discards in-flight writes and claims immediately.
- Writes:
  - On rising clk with rf_we=1 and write_addr_in != 0: mem[write_addr_in] <= write_data_in.
  - Writes are never gated by stall_in: write-back has already committed.
  - Writes to register 0 are ignored; register 0 always reads 0.
- Reads:
  - 1-cycle latency. On rising clk with stall_in=0, rd_data_x <= value of mem[rd_addr_x].
  - stall_in=1 holds rd_data_a/b and hazard_a/b.
  - Address 0 returns 0 regardless of any write.
- Scoreboard, per rising clk:
  - clear: rf_we=1 clears pending[write_addr_in] (any stall state).
  - set: claim_en=1 and stall_in=0 sets pending[claim_addr].
  - Same register set and cleared in one cycle: set wins (newer instruction outstanding).
  - Register 0 is never marked pending.
  - hazard_x <= pending[rd_addr_x] after this cycle's clear, before this cycle's set. A same-cycle write retires the hazard; a same-cycle claim does not self-hazard.
- claim_en while stall_in=1 is ignored; decode re-presents the claim.
- No wrap or overflow conditions; all indices are in range by width.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - If rf_we=1, write_addr_in == rd_addr_x and write_addr_in != 0 in the same cycle, rd_data_x captures write_data_in (write-first forwarding).
  - Register 0 still reads 0.
- Undefined:
  - Reads capture the old array contents (read-first).
  - Decode must wait one extra cycle after a hazard clears.

Decomposition:
- Shared package mips_pkg holds:
  - DATA_W and ADDR_W constants.
  - REG_ZERO = 5'd0.
  - NUM_REGS = 32.
  - A reg_addr_t typedef, shared with decode and write_back.
- One natural sub-module, rf_scoreboard: the pending vector with set/clear priority and the hazard lookups.
- The array and read/bypass muxing stay in register_file.

Test Plan:
- Reset:
  - Write r5=0xDEADBEEF.
  - Assert rst mid-cycle, then read r5 -> 0.
  - rd_data_a/b and hazard_a/b are 0 during rst.
- Write then read:
  - rf_we=1, addr=3, data=0x12345678 at cycle N.
  - rd_addr_a=3 at cycle N+1 -> rd_data_a=0x12345678 at N+2.
- Zero register: write 0xFFFFFFFF to r0, read r0 on both ports -> 0; hazard never asserted for r0.
- Bypass:
  - rf_we=1, addr=7, data=0xA5A5A5A5 and rd_addr_b=7 in the same cycle -> rd_data_b=0xA5A5A5A5 with REGFILE_BYPASS_EN.
  - Without the macro, rd_data_b shows the old value.
- Scoreboard:
  - Claim r9, then rd_addr_a=9 -> hazard_a=1.
  - Write-back to r9 -> hazard_a=0 next sample.
  - Same-cycle claim and write to r9 -> pending stays 1.
- Stall:
  - stall_in=1 with claim_en=1 for r4 and a changing rd_addr -> outputs held, r4 not pending.
  - rf_we=1 during the stall still updates the array.
